kbdmus_spi_loader: RTL

KBDMUS_SPI_LOADER -- requirements
Module: kbdmus_spi_loader

---
 rtl/kbdmus_pkg.sv | 54 +++++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/kbdmus_spi_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/kbdmus_pkg.sv
// Shared command codes, FSM state type and byte helpers for the
// keyboard/mouse SPI loader.
package kbdmus_pkg;

  localparam logic [7:0] CMD_KBD  = 8'h10;
  localparam logic [7:0] CMD_MUSX = 8'h20;
  localparam logic [7:0] CMD_MUSY = 8'h21;
  localparam logic [7:0] CMD_MUSB = 8'h22;

  localparam logic [2:0] KBD_BYTES = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_IGN
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_KBD,
    K_MX,
    K_MY,
    K_MB
  } cmd_e;

  function automatic cmd_e cmd_decode(input logic [7:0] b);
    cmd_e c;
    unique case (1'b1)
      (b == CMD_KBD):  c = K_KBD;
      (b == CMD_MUSX): c = K_MX;
      (b == CMD_MUSY): c = K_MY;
      (b == CMD_MUSB): c = K_MB;
      default:         c = K_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] kbd_byte(
    input logic [39:0] v,
    input logic [2:0]  k
  );
    logic [7:0] r;
    case (k)
      3'd0:    r = v[39:32];
      3'd1:    r = v[31:24];
      3'd2:    r = v[23:16];
      3'd3:    r = v[15:8];
      default: r = v[7:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with
// rising/falling edge strobes in the fclk domain.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/kbdmus_spi_loader.sv
// SPI slave loading a 40-bit key image and mouse bytes from the AVR.
// Optional readback of overwritten bytes: KBDMUS_SPI_READBACK_EN.
module kbdmus_spi_loader
  import kbdmus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        spics_n,
  input  logic        spick,
  input  logic        spidi,
  output logic        spido,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb
);

  logic cs_q, cs_rise, cs_fall;
  logic ck_q, ck_rise, ck_fall;
  logic di_q, di_rise, di_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(fclk), .rst_n(rst_n), .d_i(spics_n),
    .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ck (
    .clk(fclk), .rst_n(rst_n), .d_i(spick),
    .q_o(ck_q), .rise_o(ck_rise), .fall_o(ck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_di (
    .clk(fclk), .rst_n(rst_n), .d_i(spidi),
    .q_o(di_q), .rise_o(di_rise), .fall_o(di_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cs_rise, cs_fall, ck_q, ck_fall,
                          di_rise, di_fall};

  state_e      state_q, state_d;
  cmd_e        cmd_q;
  logic [2:0]  bit_q, idx_q;
  logic [6:0]  sh_q;
  logic [39:0] shadow_q, kbd_q;
  logic [7:0]  mus_q, byte_w;
  logic [5:0]  kpos;
  logic        smp, byte_done, data_done, last;
  logic        kbd_stb_q, kbd_stb_d;
  logic        mx_q, mx_d, my_q, my_d, mb_q, mb_d;

  assign smp       = ck_rise & ~cs_q & (state_q != ST_IDLE);
  assign byte_done = smp & (bit_q == 3'd7);
  assign data_done = byte_done & (state_q == ST_DATA);
  assign byte_w    = {sh_q, di_q};
  assign kpos      = 6'd32 - {idx_q, 3'b000};
  assign last      = (cmd_q != K_KBD) | (idx_q == KBD_BYTES - 3'd1);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (!cs_q) state_d = ST_CMD;
      ST_CMD:
        if (byte_done)
          state_d = (cmd_decode(byte_w) != K_NONE) ? ST_DATA : ST_IGN;
      ST_DATA: if (byte_done && last) state_d = ST_IGN;
      default: state_d = state_q;
    endcase
    if (cs_q) state_d = ST_IDLE;
  end

  always_comb begin
    kbd_stb_d = 1'b0;
    mx_d      = 1'b0;
    my_d      = 1'b0;
    mb_d      = 1'b0;
    if (data_done) begin
      unique case (cmd_q)
        K_KBD:   kbd_stb_d = last;
        K_MX:    mx_d = 1'b1;
        K_MY:    my_d = 1'b1;
        K_MB:    mb_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q     <= 3'd0;
      idx_q     <= 3'd0;
      sh_q      <= 7'd0;
      cmd_q     <= K_NONE;
      shadow_q  <= 40'h0;
      kbd_q     <= 40'h0;
      mus_q     <= 8'hFF;
      kbd_stb_q <= 1'b0;
      mx_q      <= 1'b0;
      my_q      <= 1'b0;
      mb_q      <= 1'b0;
    end else begin
      kbd_stb_q <= kbd_stb_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      mb_q      <= mb_d;
      // Idle clears everything per-transaction, dropping partial data.
      if (state_q == ST_IDLE) begin
        bit_q    <= 3'd0;
        idx_q    <= 3'd0;
        shadow_q <= 40'h0;
      end else if (smp) begin
        bit_q <= bit_q + 3'd1;
        sh_q  <= byte_w[6:0];
      end
      if (state_q == ST_CMD && byte_done)
        cmd_q <= cmd_decode(byte_w);
      if (data_done) begin
        idx_q <= idx_q + 3'd1;
        if (cmd_q == K_KBD) shadow_q[kpos +: 8] <= byte_w;
      end
      if (kbd_stb_d)
        kbd_q <= {shadow_q[39:8], byte_w};
      if (mx_d | my_d | mb_d)
        mus_q <= byte_w;
    end
  end

`ifdef KBDMUS_SPI_READBACK_EN
  logic [7:0] rb_q;

  // First fall after a completed byte keeps the MSB on the line.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rb_q <= 8'h00;
    end else if (state_q == ST_CMD && byte_done) begin
      rb_q <= (cmd_decode(byte_w) == K_KBD) ? kbd_q[39:32] : mus_q;
    end else if (data_done) begin
      rb_q <= kbd_byte(kbd_q, idx_q + 3'd1);
    end else if (state_q == ST_DATA && ck_fall && bit_q != 3'd0) begin
      rb_q <= {rb_q[6:0], 1'b0};
    end
  end

  assign spido = (state_q == ST_DATA) & rb_q[7];
`else
  assign spido = 1'b0;
`endif

  assign kbd_out    = kbd_q;
  assign kbd_stb    = kbd_stb_q;
  assign mus_out    = mus_q;
  assign mus_xstb   = mx_q;
  assign mus_ystb   = my_q;
  assign mus_btnstb = mb_q;

endmodule
